// File: rtl/instr_encoder_if.sv
// Request/instruction bundle between a micro-op source, the encoder and the
// control unit. The encoder connects through the slave modport.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        err_illegal;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, instr_ready,
        input  req_ready, instr_valid, instruction, err_illegal
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, instr_ready,
        output req_ready, instr_valid, instruction, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes micro-op requests into 32-bit instruction words and queues them in a
// DEPTH-entry FIFO. Define ENC_COUNT_EN to add the issued_count output.
module instr_encoder #(
    parameter int          DEPTH   = 4,
    parameter logic [4:0]  SHAMT_R = 5'b01010
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
`ifdef ENC_COUNT_EN
    ,
    output logic [15:0]     issued_count
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          err_r;

    logic          full_s;
    logic          empty_s;
    logic          accept_s;
    logic          illegal_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   word_s;

    // Field packing for each op; op 7 never reaches the FIFO so its word is unused.
    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'b000001, rs, rt, rd, SHAMT_R, 6'b100000};
            3'd1:    w = {6'b000001, rs, rt, rd, SHAMT_R, 6'b100010};
            3'd2:    w = {6'b000001, rs, rt, rd, SHAMT_R, 6'b100100};
            3'd3:    w = {6'b000001, rs, rt, rd, SHAMT_R, 6'b100101};
            3'd4:    w = {6'b000001, rs, rt, rd, SHAMT_R, 6'b110010};
            3'd5:    w = {6'b000010, rs, rt, imm};
            3'd6:    w = {6'b000011, rs, rt, imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Handshake decode and encoding of the current request.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        accept_s  = bus.req_valid && !full_s;
        illegal_s = (bus.req_op == 3'd7);
        push_s    = accept_s && !illegal_s;
        pop_s     = !empty_s && bus.instr_ready;
        word_s    = encode(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_imm);
    end

    // FIFO storage, pointers, occupancy and the sticky illegal-op flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[tail_r] <= word_s;
                tail_r        <= tail_r + AW'(1'b1);
            end else begin
                tail_r        <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1'b1);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
            if (accept_s && illegal_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

`ifdef ENC_COUNT_EN
    logic [15:0] issued_r;

    // Count of words taken by the consumer; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_r <= 16'h0000;
        end else if (pop_s) begin
            issued_r <= issued_r + 16'h0001;
        end else begin
            issued_r <= issued_r;
        end
    end

    assign issued_count = issued_r;
`endif

    // The head word is driven straight from storage, so it cannot move while stalled.
    always_comb begin
        bus.req_ready   = !full_s;
        bus.instr_valid = !empty_s;
        bus.err_illegal = err_r;
        if (empty_s) begin
            bus.instruction = 32'h0000_0000;
        end else begin
            bus.instruction = mem_r[head_r];
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based reference model checked every
// cycle, plus hand-computed instruction words at key points.
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if bus();
`ifdef ENC_COUNT_EN
    logic [15:0] issued_count;
`endif

    instr_encoder #(.DEPTH(DEPTH), .SHAMT_R(5'b01010)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ENC_COUNT_EN
        ,
        .issued_count(issued_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mq[$];
    bit          m_err = 1'b0;
    int unsigned m_cnt = 0;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word from plain field arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
        int funct[5] = '{32, 34, 36, 37, 50};
        longint w;
        if (op < 5)       w = 1 * (2**26) + rs * (2**21) + rt * (2**16) + rd * (2**11) + 10 * (2**6) + funct[op];
        else if (op == 5) w = 2 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        else if (op == 6) w = 3 * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        else              w = 0;
        return w[31:0];
    endfunction

    // Reference model: updated on each rising edge or on reset.
    initial forever begin : model
        bit acc;
        bit popd;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            acc  = bus.req_valid && (mq.size() < DEPTH);
            popd = (mq.size() > 0) && bus.instr_ready;
            if (popd) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (acc && bus.req_op == 3'd7) m_err = 1'b1;
            else if (acc) mq.push_back(ref_word(int'(bus.req_op), int'(bus.req_rs), int'(bus.req_rt),
                                                int'(bus.req_rd), int'(bus.req_imm)));
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst && checking) begin
            check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, mq.size() != 0});
            check("instruction", bus.instruction, (mq.size() != 0) ? mq[0] : 32'h0);
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, mq.size() != DEPTH});
            check("err_illegal", {31'd0, bus.err_illegal}, {31'd0, m_err});
`ifdef ENC_COUNT_EN
            check("issued_count", {16'd0, issued_count}, m_cnt);
`endif
        end
    end

    task automatic set_req(input int op, input int rs, input int rt, input int rd, input int imm);
        bus.req_valid = 1'b1;
        bus.req_op    = op[2:0];
        bus.req_rs    = rs[4:0];
        bus.req_rt    = rt[4:0];
        bus.req_rd    = rd[4:0];
        bus.req_imm   = imm[15:0];
    endtask

    // Present a request and hold it until the edge that accepts it.
    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
        bit ok;
        bit done;
        done = 1'b0;
        set_req(op, rs, rt, rd, imm);
        for (int k = 0; k < 50 && !done; k++) begin
            ok = bus.req_ready;
            @(posedge clk);
            #2;
            if (ok) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_op      = 3'd0;
        bus.req_rs      = 5'd0;
        bus.req_rt      = 5'd0;
        bus.req_rd      = 5'd0;
        bus.req_imm     = 16'h0000;
        bus.instr_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instruction, 32'h0);
        check("rst_err", {31'd0, bus.err_illegal}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        checking = 1'b1;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // Single LOAD with consumer ready.
        bus.instr_ready = 1'b1;
        send(5, 7, 0, 0, 16'h0500);
        check("load_word", bus.instruction, 32'h08E00500);
        check("load_valid", {31'd0, bus.instr_valid}, 32'd1);
        @(posedge clk);
        #2;
        check("load_drained", {31'd0, bus.instr_valid}, 32'd0);

        // Back-to-back MUL, SUB, STORE.
        send(4, 0, 1, 4, 0);
        check("mul_word", bus.instruction, 32'h040122B2);
        send(1, 4, 5, 6, 0);
        check("sub_word", bus.instruction, 32'h048532A2);
        send(6, 7, 6, 0, 16'h08FF);
        check("store_word", bus.instruction, 32'h0CE608FF);
        @(posedge clk);
        #2;

        // Fill to full with the consumer stalled, hold off a fifth request.
        bus.instr_ready = 1'b0;
        send(0, 1, 2, 3, 0);
        send(2, 5, 6, 7, 0);
        send(3, 8, 9, 10, 0);
        send(4, 11, 12, 13, 0);
        check("full_ready", {31'd0, bus.req_ready}, 32'd0);
        set_req(1, 14, 15, 16, 0);
        repeat (3) @(posedge clk);
        #2;
        check("full_hold", {31'd0, bus.req_ready}, 32'd0);
        check("full_head", bus.instruction, 32'h04221AA0);
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #2;
        check("ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
        send(1, 14, 15, 16, 0);
        repeat (6) @(posedge clk);
        #2;
        check("full_drained", {31'd0, bus.instr_valid}, 32'd0);

        // Two entries queued, then push and pop together for three cycles.
        bus.instr_ready = 1'b0;
        send(0, 1, 1, 1, 0);
        send(5, 2, 3, 16'h0011, 16'h00AA);
        bus.instr_ready = 1'b1;
        send(6, 31, 30, 0, 16'hFFFF);
        send(5, 3, 4, 0, 16'h1234);
        send(3, 9, 9, 9, 0);
        check("steady_head", bus.instruction, 32'h08641234);
        repeat (4) @(posedge clk);
        #2;

        // Illegal op: flag sets, nothing is queued, flag survives legal traffic.
        send(7, 1, 2, 3, 16'h0F0F);
        check("illegal_err", {31'd0, bus.err_illegal}, 32'd1);
        check("illegal_empty", {31'd0, bus.instr_valid}, 32'd0);
        send(2, 4, 4, 4, 0);
        send(6, 1, 2, 0, 16'h0004);
        repeat (3) @(posedge clk);
        #2;
        check("illegal_sticky", {31'd0, bus.err_illegal}, 32'd1);

        // Asynchronous reset with three entries queued.
        bus.instr_ready = 1'b0;
        send(0, 1, 2, 3, 0);
        send(1, 1, 2, 3, 0);
        send(2, 1, 2, 3, 0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("mid_rst_err", {31'd0, bus.err_illegal}, 32'd0);
        check("mid_rst_instr", bus.instruction, 32'h0);
`ifdef ENC_COUNT_EN
        check("mid_rst_count", {16'd0, issued_count}, 32'd0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // Five legal and one illegal op issued.
        bus.instr_ready = 1'b1;
        send(0, 2, 3, 4, 0);
        send(5, 6, 7, 0, 16'h0010);
        send(7, 0, 0, 0, 0);
        send(6, 6, 7, 0, 16'h0020);
        send(4, 8, 9, 10, 0);
        send(3, 1, 1, 2, 0);
        repeat (4) @(posedge clk);
        #2;
        check("count_drained", {31'd0, bus.instr_valid}, 32'd0);
`ifdef ENC_COUNT_EN
        check("issued_five", {16'd0, issued_count}, 32'd5);
        rst = 1'b1;
        #1;
        check("issued_reset", {16'd0, issued_count}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
